uart_frame_decoder: RTL and testbench

Receive-side decoder for the filament-sensor serial frame: an ASCII header `"SYNC"` followed by an unbounded stream of one-byte samples, where each byte is ADC[11:4]. The block sits behind a byte-level UART receiver in the host-side FPGA or bridge. It hunts for the header, locks, and rebuilds a 12-bit sample from every subsequent byte. An optional idle watchdog drops lock so the decoder can re-acquire after the transmitter re-syncs.

---
 rtl/uart_frame_pkg.sv | 23 ++
 rtl/uart_rx_watchdog.sv | 35 +++
 rtl/uart_frame_decoder.sv | 115 +++++++++++
 tb/tb_uart_frame_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the filament-sensor frame decoder: state encoding and
// the "SYNC" header bytes also used by the transmitter side.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    HUNT,
    GOT_S,
    GOT_Y,
    GOT_N,
    LOCKED
  } dec_state_e;

  localparam logic [7:0] SYNC_S = 8'h53;
  localparam logic [7:0] SYNC_Y = 8'h59;
  localparam logic [7:0] SYNC_N = 8'h4E;
  localparam logic [7:0] SYNC_C = 8'h43;

  // A broken header may itself be the start of a fresh one.
  function automatic dec_state_e restart_state(input logic [7:0] b);
    return (b == SYNC_S) ? GOT_S : HUNT;
  endfunction

endpackage

// File: rtl/uart_rx_watchdog.sv
// Idle watchdog: counts clocks without a received byte while the decoder is
// out of HUNT and pulses expired_o on the TIMEOUT_CYCLES-th idle clock.
module uart_rx_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic rx_valid_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired_o = active_i && !rx_valid_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q + CW'(1);
    if (!active_i || rx_valid_i || expired_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Hunts for the "SYNC" header, then rebuilds a 12-bit sample from every byte.
// Optional idle watchdog enabled by defining UART_DEC_TIMEOUT_EN.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             resync,
  output logic [11:0]      sample,
  output logic             sample_valid,
  output logic             locked,
  output logic             hdr_err,
  output logic [CNT_W-1:0] sample_count
);

  dec_state_e       state_q, state_d;
  logic [11:0]      sample_q, sample_d;
  logic             sample_valid_q, sample_valid_d;
  logic             hdr_err_q, hdr_err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             expired;
  logic             take_byte;

`ifdef UART_DEC_TIMEOUT_EN
  uart_rx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .active_i  (state_q != HUNT),
    .rx_valid_i(rx_valid),
    .expired_o (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // resync discards the byte presented in the same cycle
  assign take_byte = rx_valid && !resync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (resync || expired) begin
      state_d = HUNT;
    end else if (rx_valid) begin
      unique case (state_q)
        HUNT:    state_d = restart_state(rx_data);
        GOT_S:   state_d = (rx_data == SYNC_Y) ? GOT_Y  : restart_state(rx_data);
        GOT_Y:   state_d = (rx_data == SYNC_N) ? GOT_N  : restart_state(rx_data);
        GOT_N:   state_d = (rx_data == SYNC_C) ? LOCKED : restart_state(rx_data);
        LOCKED:  state_d = LOCKED;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    hdr_err_d      = 1'b0;
    count_d        = count_q;
    if (take_byte) begin
      unique case (state_q)
        GOT_S:   hdr_err_d = (rx_data != SYNC_Y);
        GOT_Y:   hdr_err_d = (rx_data != SYNC_N);
        GOT_N: begin
          hdr_err_d = (rx_data != SYNC_C);
          if (rx_data == SYNC_C) begin
            count_d = '0;
          end
        end
        LOCKED: begin
          sample_d       = {rx_data, 4'h0};
          sample_valid_d = 1'b1;
          count_d        = count_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      hdr_err_q      <= 1'b0;
      count_q        <= '0;
    end else begin
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      hdr_err_q      <= hdr_err_d;
      count_q        <= count_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign hdr_err      = hdr_err_q;
  assign sample_count = count_q;
  assign locked       = (state_q == LOCKED);

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: directed frames plus random byte
// traffic compared against a header-progress reference model.
module tb_uart_frame_decoder;

  localparam int TB_CNT_W   = 4;
  localparam int TB_TIMEOUT = 100;
  localparam int CNT_MOD    = 1 << TB_CNT_W;

  logic                clk;
  logic                rst_n;
  logic [7:0]          rxData;
  logic                rxValid;
  logic                resync;
  logic [11:0]         sample;
  logic                sampleValid;
  logic                locked;
  logic                hdrErr;
  logic [TB_CNT_W-1:0] sampleCount;

  int testCount;
  int failCount;

  // model state: how many header bytes matched so far (4 = locked)
  int          hdrPos;
  int          idleClocks;
  logic [7:0]  hdrBytes [4];
  logic [11:0] expSample;
  logic        expSv;
  logic        expErr;
  int          expCount;

  uart_frame_decoder #(
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .CNT_W         (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rxData),
    .rx_valid    (rxValid),
    .resync      (resync),
    .sample      (sample),
    .sample_valid(sampleValid),
    .locked      (locked),
    .hdr_err     (hdrErr),
    .sample_count(sampleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    hdrPos     = 0;
    idleClocks = 0;
    expSample  = '0;
    expSv      = 1'b0;
    expErr     = 1'b0;
    expCount   = 0;
  endtask

  task automatic modelStep(input logic v, input logic [7:0] d, input logic rs);
    expSv  = 1'b0;
    expErr = 1'b0;
    if (rs) begin
      hdrPos     = 0;
      idleClocks = 0;
    end else if (v) begin
      idleClocks = 0;
      if (hdrPos == 4) begin
        expSample = {d, 4'h0};
        expSv     = 1'b1;
        expCount  = (expCount + 1) % CNT_MOD;
      end else if (d == hdrBytes[hdrPos]) begin
        hdrPos++;
        if (hdrPos == 4) expCount = 0;
      end else begin
        expErr = (hdrPos > 0);
        hdrPos = (d == hdrBytes[0]) ? 1 : 0;
      end
    end else if (hdrPos != 0) begin
`ifdef UART_DEC_TIMEOUT_EN
      idleClocks++;
      if (idleClocks == TB_TIMEOUT) begin
        hdrPos     = 0;
        idleClocks = 0;
      end
`endif
    end
  endtask

  task automatic checkAll();
    checkOutput("locked", 32'(locked), 32'(hdrPos == 4));
    checkOutput("sample_valid", 32'(sampleValid), 32'(expSv));
    checkOutput("sample", 32'(sample), 32'(expSample));
    checkOutput("hdr_err", 32'(hdrErr), 32'(expErr));
    checkOutput("sample_count", 32'(sampleCount), 32'(expCount));
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rs);
    rxValid = v;
    rxData  = d;
    resync  = rs;
    @(posedge clk);
    modelStep(v, d, rs);
    #1;
    checkAll();
    rxValid = 1'b0;
    resync  = 1'b0;
  endtask

  task automatic sendHeader();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, hdrBytes[i], 1'b0);
  endtask

  task automatic idleFor(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] stream1 [7];
    logic [7:0] stream2 [7];
    testCount   = 0;
    failCount   = 0;
    hdrBytes[0] = 8'h53;
    hdrBytes[1] = 8'h59;
    hdrBytes[2] = 8'h4E;
    hdrBytes[3] = 8'h43;
    stream1     = '{8'h53, 8'h59, 8'h4E, 8'h43, 8'hA5, 8'h00, 8'hFF};
    stream2     = '{8'h53, 8'h59, 8'h53, 8'h59, 8'h4E, 8'h43, 8'h12};
    modelReset();
    rxValid = 1'b0;
    rxData  = 8'h00;
    resync  = 1'b0;
    rst_n   = 1'b0;
    #22;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    // basic lock and three samples
    foreach (stream1[i]) applyStimulus(1'b1, stream1[i], 1'b0);
    checkOutput("count_after_three", 32'(sampleCount), 32'd3);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // broken header recovers on an embedded 'S'
    foreach (stream2[i]) applyStimulus(1'b1, stream2[i], 1'b0);

    // header bytes are plain data while locked
    sendHeader();
    checkOutput("count_no_relock", 32'(sampleCount), 32'd5);

    // resync beats a simultaneous byte
    applyStimulus(1'b1, 8'h77, 1'b1);
    checkOutput("count_held", 32'(sampleCount), 32'd5);

    // counter wrap at 2^CNT_W
    sendHeader();
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    checkOutput("count_wrap", 32'(sampleCount), 32'd1);

    // idle behaviour: a byte on the 100th clock keeps lock, 100 idle clocks may drop it
    idleFor(TB_TIMEOUT - 1);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    idleFor(TB_TIMEOUT);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // stalled partial header
    applyStimulus(1'b1, 8'h53, 1'b0);
    applyStimulus(1'b1, 8'h59, 1'b0);
    idleFor(TB_TIMEOUT + 2);
    applyStimulus(1'b1, 8'h4E, 1'b0);

    // random traffic biased toward header bytes
    for (int n = 0; n < 3000; n++) begin
      int unsigned pick;
      logic [7:0]  b;
      pick = $urandom_range(0, 99);
      b    = (pick < 50) ? hdrBytes[$urandom_range(0, 3)] : 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        idleFor(TB_TIMEOUT + $urandom_range(0, 20) - 10);
      end else if ($urandom_range(0, 49) == 0) begin
        sendHeader();
      end else begin
        applyStimulus($urandom_range(0, 9) < 6, b, $urandom_range(0, 49) == 0);
      end
    end

    // asynchronous reset in the middle of a header
    applyStimulus(1'b0, 8'h00, 1'b1);
    sendHeader();
    applyStimulus(1'b1, 8'hC3, 1'b0);
    applyStimulus(1'b1, 8'h81, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h53, 1'b0);
    applyStimulus(1'b1, 8'h59, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h4E, 1'b0);
    applyStimulus(1'b1, 8'h43, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
